// File: rtl/key_queue_pkg.sv
// Shared key codes and keycode bus layout for the keyboard front end and the
// top-level direction decoder.
package key_queue_pkg;

  localparam int unsigned KEY_W        = 7;
  localparam int unsigned KC_W         = 8;
  localparam int unsigned KC_VALID_BIT = 7;

  localparam logic [KEY_W-1:0] KEY_UP    = 7'h77;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 7'h73;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 7'h61;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 7'h64;

  // True for the four movement keys ('w', 's', 'a', 'd').
  function automatic logic is_direction(input logic [KEY_W-1:0] code);
    return (code == KEY_UP) || (code == KEY_DOWN) ||
           (code == KEY_LEFT) || (code == KEY_RIGHT);
  endfunction

endpackage

// File: rtl/key_filter.sv
// Combinational push qualifier: passes direction keys only, or everything
// when FILTER is 0.
module key_filter
  import key_queue_pkg::*;
#(
  parameter bit FILTER = 1'b1
) (
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             accept_c
);

  always_comb begin
    accept_c = 1'b0;
    if (key_valid) begin
      accept_c = FILTER ? is_direction(key_in) : 1'b1;
    end
  end

endmodule

// File: rtl/key_queue.sv
// Small FIFO of accepted key codes; the head entry is presented on keycode
// with a valid flag and is consumed by keystrobe.
module key_queue
  import key_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter bit          FILTER = 1'b1,
  parameter bit          DEDUP  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [KEY_W-1:0]         key_in,
  input  logic                     key_valid,
  output logic [KC_W-1:0]          keycode,
  input  logic                     keystrobe,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [KEY_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd;
  logic [PW-1:0]    wr;

  logic             accept_c;
  logic             pop_c;
  logic             full_c;
  logic             dup_c;
  logic             push_c;
  logic             drop_c;
  logic [CW-1:0]    remain_c;
  logic [KEY_W-1:0] newest_c;

  key_filter #(.FILTER(FILTER)) u_filter (
    .key_in    (key_in),
    .key_valid (key_valid),
    .accept_c  (accept_c)
  );

  // Dedup looks at the newest entry as the queue will stand after this cycle's pop.
  always_comb begin
    pop_c    = keystrobe && (count != '0);
    full_c   = (count == CW'(DEPTH));
    remain_c = count - CW'(pop_c);
    newest_c = mem[wr - PW'(1)];
    dup_c    = DEDUP && (remain_c != '0) && (key_in == newest_c);
    push_c   = accept_c && !dup_c && (!full_c || pop_c);
    drop_c   = accept_c && !dup_c && full_c && !pop_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr <= wr + PW'(1);
      if (pop_c)  rd <= rd + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr] <= key_in;
  end

  // Head decode from registers only, so keycode never depends on this cycle's inputs.
  always_comb begin
    keycode = '0;
    if (count != '0) begin
      keycode[KC_VALID_BIT]  = 1'b1;
      keycode[KEY_W-1:0]     = mem[rd];
    end
  end

endmodule
